// File: rtl/mlp_batch_sequencer.sv
// mlp_batch_sequencer
// -------------------
// On-chip initiator for the MLP classifier core. A run pulse walks sample
// indices 0..NUM_SAMPLES-1. For each index the block pulses mlp_start and
// waits for mlp_done, with a per-sample timeout. It then encodes the one-hot
// winning class and compares it against an external label ROM. Accuracy
// counters accumulate over the batch.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   run               one-cycle batch start (honoured only in IDLE/FINISH)
//   mlp_start         one-cycle start pulse to the MLP core
//   mlp_index         sample index, held from start until the result is taken
//   mlp_done          MLP result ready (level or pulse)
//   mlp_max           one-hot winning class from the MLP
//   label_addr        label ROM address (always equal to mlp_index)
//   label_data        label ROM data, valid one cycle after label_addr
//   pred_valid        one-cycle strobe per finished sample
//   pred_index        index of the reported sample (0 outside the strobe)
//   pred_class        encoded class 0..9, or 15 for invalid/timeout
//   pred_correct      pred_class matches the label
//   correct_count     correct predictions this batch (saturating)
//   sample_count      samples reported this batch (saturating)
//   err_count         invalid one-hot plus timeout events (saturating)
//   busy              high in ISSUE/WAIT/REPORT
//   finished          high in FINISH until the next run or rst
module mlp_batch_sequencer #(
    parameter int NUM_SAMPLES = 750,
    parameter int TIMEOUT     = 1023,
    parameter int CLASSES     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               mlp_start,
    output logic [9:0]         mlp_index,
    input  logic               mlp_done,
    input  logic [CLASSES-1:0] mlp_max,
    output logic [9:0]         label_addr,
    input  logic [3:0]         label_data,
    output logic               pred_valid,
    output logic [9:0]         pred_index,
    output logic [3:0]         pred_class,
    output logic               pred_correct,
    output logic [9:0]         correct_count,
    output logic [9:0]         sample_count,
    output logic [9:0]         err_count,
    output logic               busy,
    output logic               finished
);

    localparam int         TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [9:0] LAST_IDX = 10'(NUM_SAMPLES - 1);
    localparam logic [9:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_REPORT, S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [9:0]         index_q, index_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]         label_q, label_d;
    logic [CLASSES-1:0] max_q, max_d;
    logic               timed_out_q, timed_out_d;
    logic [9:0]         correct_q, correct_d;
    logic [9:0]         sample_q, sample_d;
    logic [9:0]         err_q, err_d;

    logic       first_wait, done_ok, tmo_hit;
    logic [3:0] enc_class, rep_class;
    logic       invalid, rep_correct;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    // The timeout counter is cleared in ISSUE, so zero marks the first WAIT
    // cycle. A done seen then may be a stale level from the previous sample.
    assign first_wait = (tmo_q == '0);
    assign done_ok    = mlp_done && !first_wait;
    assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT));

    // One-hot decode of the captured vector. A timeout or a vector without
    // exactly one bit set reports class 15 and is never counted as correct.
    always_comb begin
        enc_class = 4'd0;
        for (int i = 0; i < CLASSES; i++) begin
            if (max_q[i]) enc_class = 4'(i);
        end
        invalid     = timed_out_q || ($countones(max_q) != 1);
        rep_class   = invalid ? 4'd15 : enc_class;
        rep_correct = !invalid && (enc_class == label_q);
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        index_d     = index_q;
        tmo_d       = tmo_q;
        label_d     = label_q;
        max_d       = max_q;
        timed_out_d = timed_out_q;
        correct_d   = correct_q;
        sample_d    = sample_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                if (run) begin
                    correct_d = '0;
                    sample_d  = '0;
                    err_d     = '0;
                    index_d   = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d       = '0;
                timed_out_d = 1'b0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // The ROM address was presented in ISSUE, so the data is valid now.
                if (first_wait) label_d = label_data;
                // Done takes priority over a timeout in the same cycle.
                if (done_ok) begin
                    max_d   = mlp_max;
                    state_d = S_REPORT;
                end else if (tmo_hit) begin
                    timed_out_d = 1'b1;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                sample_d = sat_inc(sample_q);
                if (rep_correct) correct_d = sat_inc(correct_q);
                if (invalid)     err_d     = sat_inc(err_q);
                if (index_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    index_d = index_q + 10'd1;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            tmo_q       <= '0;
            label_q     <= '0;
            max_q       <= '0;
            timed_out_q <= 1'b0;
            correct_q   <= '0;
            sample_q    <= '0;
            err_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments update all registers together at
            // the edge, so no register sees another's new value within a cycle.
            state_q     <= state_d;
            index_q     <= index_d;
            tmo_q       <= tmo_d;
            label_q     <= label_d;
            max_q       <= max_d;
            timed_out_q <= timed_out_d;
            correct_q   <= correct_d;
            sample_q    <= sample_d;
            err_q       <= err_d;
        end
    end

    assign mlp_start     = (state_q == S_ISSUE);
    assign mlp_index     = index_q;
    assign label_addr    = index_q;
    assign pred_valid    = (state_q == S_REPORT);
    assign pred_index    = pred_valid ? index_q : '0;
    assign pred_class    = pred_valid ? rep_class : '0;
    assign pred_correct  = pred_valid && rep_correct;
    assign correct_count = correct_q;
    assign sample_count  = sample_q;
    assign err_count     = err_q;
    assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                           (state_q == S_REPORT);
    assign finished      = (state_q == S_FINISH);

endmodule

// File: doc/mlp_batch_sequencer.md
Name: mlp_batch_sequencer

Overview:
- Hardware initiator for the MLP classifier core. It replaces bench-driven start/index stimulus with an on-chip sequencer.
- Walks sample indices 0..NUM_SAMPLES-1 and pulses the MLP start for each one, then waits for done.
- Captures the one-hot max vector, encodes it, compares it against a label ROM and accumulates accuracy counters.
- Sits between the top-level control/host and the MLP core; the label ROM is external.

Parameters:
- NUM_SAMPLES, 750, number of samples per run (1..1023)
- TIMEOUT, 1023, max cycles to wait for mlp_done per sample
- CLASSES, 10, width of one-hot max vector

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  one-cycle pulse; starts a batch (ignored unless IDLE or FINISH)
- mlp_start  out  1  one-cycle start pulse to MLP
- mlp_index  out  10  sample index to MLP, stable from start until done
- mlp_done  in  1  MLP result ready (level or pulse)
- mlp_max  in  10  one-hot winning class from MLP
- label_addr  out  10  label ROM address (= mlp_index)
- label_data  in  4  label ROM data, registered read, valid 1 cycle after address
- pred_valid  out  1  one-cycle strobe per finished sample
- pred_index  out  10  index of reported sample
- pred_class  out  4  encoded class 0..9; 15 if the vector is invalid
- pred_correct  out  1  pred_class == label
- correct_count  out  10  correct predictions this batch
- sample_count  out  10  samples reported this batch
- err_count  out  10  invalid-onehot + timeout events this batch
- busy  out  1  high in any state except IDLE/FINISH
- finished  out  1  high in FINISH until next run or rst

Behaviour:
- Reset (rst high at a clock edge) has priority over everything, including mid-batch.
- Reset values: all outputs 0, state IDLE, index 0, mlp_start 0.
- States are IDLE, ISSUE, WAIT, REPORT, FINISH.
- IDLE / FINISH:
  - On run: clear the counters, set index=0, drop finished, go to ISSUE.
- ISSUE (1 cycle):
  - Drive mlp_start=1 and set label_addr=index.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - mlp_done is ignored on the first WAIT cycle. This guards against a stale done level left over from the previous sample.
  - label_data is latched on the first WAIT cycle.
  - The timeout counter increments every cycle.
  - mlp_done=1 (from the second cycle on): latch mlp_max, go to REPORT.
  - Timeout counter reaches TIMEOUT with no done: treat as invalid (pred_class=15), go to REPORT.
  - If done and timeout occur in the same cycle, done wins.
- REPORT (1 cycle):
  - Pulse pred_valid, present pred_index/pred_class/pred_correct, increment sample_count.
  - correct_count increments iff pred_correct.
  - err_count increments on timeout or invalid one-hot.
  - If index==NUM_SAMPLES-1, go to FINISH. Otherwise increment index and go to ISSUE.
- One-hot encode:
  - Exactly one bit set at position k gives k.
  - Zero bits or multiple bits set gives 15, and pred_correct=0.
- Latency: start-to-report = (cycles until accepted done) + 1. Minimum per-sample period = 4 cycles (ISSUE, 2x WAIT, REPORT).
- run is ignored while busy. A run arriving in FINISH restarts the batch and clears the counters.
- The counters saturate at 1023. They cannot overflow for NUM_SAMPLES<=1023.
- mlp_index and label_addr hold their value in WAIT/REPORT. In FINISH they hold the last index.

Test Plan:
- Reset then run, NUM_SAMPLES=3, MLP model returns done 5 cycles after start, max=10'b0000001000, labels {3,3,7} -> three pred_valid pulses with pred_class=3 and pred_correct=1,1,0. Final correct_count=2, sample_count=3, err_count=0, finished=1, busy=0.
- mlp_done held high continuously -> each sample still takes exactly 4 cycles. Indices 0,1,2 are reported in order, and no sample is skipped or double-counted.
- mlp_max=10'b0000000000 for sample 0, then 10'b1000000001 for sample 1 -> pred_class=15 both times, pred_correct=0, err_count=2.
- MLP never asserts done, TIMEOUT=8 -> REPORT after 9 WAIT cycles, pred_class=15, err_count increments, next index issued.
- rst asserted in WAIT of sample 1 -> next cycle all outputs 0, state IDLE. A subsequent run restarts from index 0 with cleared counters.
- run pulsed while busy -> ignored, batch unaffected. run pulsed in FINISH -> finished drops, counters clear, index restarts at 0.
